dvp_tx: RTL
===========

Name: dvp_tx

Overview:
- DVP (parallel camera-bus) transmitter. It is the source end of the interface our camera input path receives: cmos_vsync, cmos_href, cmos_db[7:0] sampled on pclk.
- Consumes a 16-bit RGB565 pixel stream over a valid/ready handshake and emits OV5640-style frames: vsync pulse, href-gated lines, two bytes per pixel, high byte first.
- Used as a camera emulator / loopback source to drive the video-input path without a sensor, and as a DVP output port.

Parameters:
- H_ACT, 1280, active pixels per line (output is 2*H_ACT bytes).
- V_ACT, 720, active lines per frame.
- H_BLANK, 64, href-low cycles per line; minimum 2.
- VS_LINES, 2, line periods with dvp_vsync high; minimum 1.
- VBP_LINES, 8, idle line periods after vsync; may be 0.
- VFP_LINES, 4, idle line periods after the last active line; may be 0.

Ports:
- clk  in  1  pixel/byte clock; also serves as the DVP pclk.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  frame generation enable; sampled only at frame boundaries.
- pix_data  in  16  RGB565 pixel.
- pix_valid  in  1  pix_data is valid.
- pix_ready  out  1  block accepts a pixel this cycle.
- dvp_vsync  out  1  frame sync, active high.
- dvp_href  out  1  line data valid, active high.
- dvp_data  out  8  byte bus.
- frame_done  out  1  one-cycle pulse marking the end of a frame.
- underflow  out  1  at least one pixel in the current frame was missing.

Behaviour:
- Definitions:
  - LINE_TOTAL = 2*H_ACT + H_BLANK cycles.
  - FRAME_TOTAL = (VS_LINES + VBP_LINES + V_ACT + VFP_LINES) * LINE_TOTAL.
  - Counter widths: h_cnt is clog2(LINE_TOTAL) bits; v_cnt is clog2 of the largest line count.
- Reset: state IDLE, counters 0, all outputs 0.
- States: IDLE, VSYNC, VBP, ACTIVE, VFP. The line counter h_cnt runs 0..LINE_TOTAL-1 in every non-IDLE state; v_cnt counts lines within the current state.
- IDLE:
  - All outputs 0.
  - If enable=1, go to VSYNC; dvp_vsync is high from the next cycle. This cycle is frame cycle 0.
- VSYNC:
  - dvp_vsync=1 for exactly VS_LINES*LINE_TOTAL cycles.
  - Then go to VBP, or straight to ACTIVE if VBP_LINES=0.
- VBP: all outputs low for VBP_LINES*LINE_TOTAL cycles, then ACTIVE.
- ACTIVE: each line is dvp_href=1 for 2*H_ACT cycles, then dvp_href=0 for H_BLANK cycles, repeated V_ACT times. Then go to VFP, or to the end of frame if VFP_LINES=0.
- Byte order: pixel k of a line drives pix_data[15:8] on href byte 2k and pix_data[7:0] on byte 2k+1.
- dvp_data is 8'h00 whenever dvp_href=0.
- Handshake:
  - pix_ready is decoded from state/counters only and never depends on pix_valid.
  - It is high for exactly one cycle per pixel: the cycle immediately before that pixel's high byte appears. For pixel 0 this is the last cycle before href rises (last VBP/VSYNC/blank cycle).
  - Capture happens on pix_ready && pix_valid; the captured pixel is held for its two byte cycles.
  - Exactly H_ACT*V_ACT pix_ready pulses per frame.
- Underflow:
  - If pix_valid=0 while pix_ready=1, that pixel is emitted as 8'h00, 8'h00, underflow goes to 1, and timing continues with no stall.
  - underflow is sticky for the frame and clears to 0 on the cycle dvp_vsync rises for the next frame.
- End of frame:
  - frame_done=1 in the final cycle of the frame, i.e. the last VFP cycle, or the last cycle of the last active line if VFP_LINES=0.
  - Next state is VSYNC if enable=1 in that cycle (vsync rises on the next cycle, with no gap), else IDLE.
- Enable:
  - Deasserting enable mid-frame has no effect until the frame completes.
  - Asserting it while IDLE starts a frame with the 1-cycle latency above.
- Outputs are registered, with no combinational path from inputs to dvp_*.
- Reset asserted mid-frame forces every output to 0 immediately (asynchronously). Generation restarts from IDLE after release.

Test Plan:
- Reset and disabled idle: use H_ACT=4, V_ACT=2, H_BLANK=4, VS=1, VBP=1, VFP=1, so LINE_TOTAL=12 and FRAME_TOTAL=60. Reset, enable=0 for 100 cycles -> all outputs 0 and no pix_ready.
- Single frame, same parameters: raise enable for 1 cycle, with pix_valid=1 and pix_data incrementing from 16'h0102 per accepted pixel ->
  - vsync high for 12 cycles; href rises at frame cycle 24.
  - Line-0 bytes: 01,02,01,03,01,04,01,05.
  - Exactly 8 pix_ready pulses.
  - frame_done at frame cycle 59; then IDLE.
- Back-to-back frames, same parameters: hold enable=1 -> vsync rises again exactly 60 cycles after the first rise; underflow stays 0.
- Underflow: drop pix_valid at the 3rd pix_ready of frame 1 ->
  - bytes 4,5 of line 0 are 00,00; underflow=1 until the next vsync rise, then 0.
  - Later pixels keep their sequence (no slip).
- Zero porches: VBP=0, VFP=0 -> href rises immediately after the 12 vsync cycles; frame_done lands on the last blank cycle of line 1; FRAME_TOTAL=36.
- Reset mid-frame: assert rst_n=0 during an href byte -> dvp_href, dvp_data and pix_ready are 0 asynchronously; after release with enable=1, the frame restarts cleanly from vsync.

Source files
------------

// File: rtl/dvp_tx.sv
// DVP (parallel camera-bus) transmitter: turns a valid/ready RGB565 pixel stream
// into vsync / href-gated frames, two bytes per pixel, high byte first.
module dvp_tx #(
  parameter int unsigned H_ACT     = 1280,
  parameter int unsigned V_ACT     = 720,
  parameter int unsigned H_BLANK   = 64,
  parameter int unsigned VS_LINES  = 2,
  parameter int unsigned VBP_LINES = 8,
  parameter int unsigned VFP_LINES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic [7:0]  dvp_data,
  output logic        frame_done,
  output logic        underflow
);

  localparam int unsigned LINE_TOTAL = 2 * H_ACT + H_BLANK;
  localparam int unsigned MAX_A      = (VS_LINES > VBP_LINES) ? VS_LINES : VBP_LINES;
  localparam int unsigned MAX_B      = (V_ACT > VFP_LINES) ? V_ACT : VFP_LINES;
  localparam int unsigned MAX_LINES  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned H_W        = $clog2(LINE_TOTAL);
  localparam int unsigned V_W        = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;

  localparam logic [H_W-1:0] H_LAST   = H_W'(LINE_TOTAL - 1);
  localparam logic [H_W-1:0] H_BYTES  = H_W'(2 * H_ACT);
  localparam logic [V_W-1:0] VS_LAST  = V_W'(VS_LINES - 1);
  localparam logic [V_W-1:0] VBP_LAST = (VBP_LINES > 0) ? V_W'(VBP_LINES - 1) : '0;
  localparam logic [V_W-1:0] ACT_LAST = V_W'(V_ACT - 1);
  localparam logic [V_W-1:0] VFP_LAST = (VFP_LINES > 0) ? V_W'(VFP_LINES - 1) : '0;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBP,
    ACTIVE,
    VFP
  } state_t;

  state_t         state_q, state_d;
  logic [H_W-1:0] h_cnt_q, h_cnt_d;
  logic [V_W-1:0] v_cnt_q, v_cnt_d;
  logic [15:0]    pix_q, pix_d;
  logic           pix_ready_q, pix_ready_d;
  logic           vsync_q, vsync_d;
  logic           href_q, href_d;
  logic [7:0]     data_q, data_d;
  logic           frame_done_q, frame_done_d;
  logic           underflow_q, underflow_d;

  function automatic logic last_line(input state_t s, input logic [V_W-1:0] v);
    logic r;
    case (s)
      VSYNC:   r = (v == VS_LAST);
      VBP:     r = (v == VBP_LAST);
      ACTIVE:  r = (v == ACT_LAST);
      VFP:     r = (v == VFP_LAST);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // True in the cycle immediately before a pixel's high byte is on the bus.
  function automatic logic is_ready(input state_t s, input logic [H_W-1:0] h,
                                    input logic [V_W-1:0] v);
    logic r;
    case (s)
      VSYNC:   r = (VBP_LINES == 0) && (h == H_LAST) && (v == VS_LAST);
      VBP:     r = (h == H_LAST) && (v == VBP_LAST);
      ACTIVE:  r = ((h < (H_BYTES - H_W'(1))) && h[0]) ||
                   ((h == H_LAST) && (v != ACT_LAST));
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_frame_end(input state_t s, input logic [H_W-1:0] h,
                                        input logic [V_W-1:0] v);
    logic r;
    if (VFP_LINES != 0) r = (s == VFP) && (h == H_LAST) && (v == VFP_LAST);
    else                r = (s == ACTIVE) && (h == H_LAST) && (v == ACT_LAST);
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (state_q == IDLE) begin
      if (enable) begin
        state_d = VSYNC;
        h_cnt_d = '0;
        v_cnt_d = '0;
      end
    end else if (h_cnt_q != H_LAST) begin
      h_cnt_d = h_cnt_q + H_W'(1);
    end else begin
      h_cnt_d = '0;
      if (!last_line(state_q, v_cnt_q)) begin
        v_cnt_d = v_cnt_q + V_W'(1);
      end else begin
        v_cnt_d = '0;
        case (state_q)
          VSYNC:   state_d = (VBP_LINES != 0) ? VBP : ACTIVE;
          VBP:     state_d = ACTIVE;
          ACTIVE:  state_d = (VFP_LINES != 0) ? VFP : (enable ? VSYNC : IDLE);
          VFP:     state_d = enable ? VSYNC : IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Outputs are registered from the decode of the next position, so each output
  // register always matches the position held in state_q/h_cnt_q/v_cnt_q.
  always_comb begin
    vsync_d      = (state_d == VSYNC);
    href_d       = (state_d == ACTIVE) && (h_cnt_d < H_BYTES);
    pix_ready_d  = is_ready(state_d, h_cnt_d, v_cnt_d);
    frame_done_d = is_frame_end(state_d, h_cnt_d, v_cnt_d);

    pix_d = pix_q;
    if (pix_ready_q) pix_d = pix_valid ? pix_data : '0;

    data_d = '0;
    if (href_d) data_d = h_cnt_d[0] ? pix_q[7:0] : pix_d[15:8];

    underflow_d = underflow_q;
    if ((state_d == VSYNC) && (state_q != VSYNC)) underflow_d = 1'b0;
    else if (pix_ready_q && !pix_valid)           underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      pix_q        <= '0;
      pix_ready_q  <= 1'b0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      pix_q        <= pix_d;
      pix_ready_q  <= pix_ready_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
      underflow_q  <= underflow_d;
    end
  end

  assign pix_ready  = pix_ready_q;
  assign dvp_vsync  = vsync_q;
  assign dvp_href   = href_q;
  assign dvp_data   = data_q;
  assign frame_done = frame_done_q;
  assign underflow  = underflow_q;

endmodule
